// File: rtl/cofre_controle.sv
// ---------------------------------------------------------------------------
// cofre_controle
//
// Sequential control stage for the safe. It takes the verdict of the
// combinational comparator for each attempt. From that verdict it opens the
// safe with an automatic relock, counts failed attempts and enters a timed
// lockout once too many attempts have failed. It also latches the hint and
// error indications that drive the user-facing LEDs.
//
// Parameters
//   MAX_TENTATIVAS  failed attempts allowed before lockout   (1..15)
//   TEMPO_BLOQUEIO  cycles spent in lockout                   (1..255)
//   TEMPO_ABERTO    cycles the safe stays open unattended     (1..255)
//
// Ports
//   clk                   system clock; all state updates on the rising edge
//   reset                 synchronous, active-high reset
//   confirmar             one-cycle pulse: submit the current attempt
//   fechar                request to close the safe (used only while open)
//   led0 / led1 / led2    comparator verdict: exact / within 3 / wrong
//   diferenca             comparator absolute difference
//   aberto                safe unlocked
//   bloqueado             lockout active
//   dica_proxima          the last failed attempt was within 3
//   erro                  the last attempt failed
//   tentativas_restantes  attempts left before lockout
//   tempo_restante        cycles left in ABERTO/BLOQUEADO, 0 in FECHADO
//   ultima_diferenca      diferenca captured at the last accepted attempt
//
// Every output is a register, so a response appears one cycle after the
// edge that sampled the input.
// ---------------------------------------------------------------------------
module cofre_controle #(
    parameter int MAX_TENTATIVAS = 3,
    parameter int TEMPO_BLOQUEIO = 16,
    parameter int TEMPO_ABERTO   = 32
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       confirmar,
    input  logic       fechar,
    input  logic       led0,
    input  logic       led1,
    input  logic       led2,
    input  logic [3:0] diferenca,
    output logic       aberto,
    output logic       bloqueado,
    output logic       dica_proxima,
    output logic       erro,
    output logic [3:0] tentativas_restantes,
    output logic [7:0] tempo_restante,
    output logic [3:0] ultima_diferenca
);

    localparam logic [3:0] MAX_C      = 4'(MAX_TENTATIVAS);
    localparam logic [7:0] BLOQUEIO_C = 8'(TEMPO_BLOQUEIO);
    localparam logic [7:0] ABERTO_C   = 8'(TEMPO_ABERTO);

    typedef enum logic [1:0] {
        FECHADO   = 2'd0,
        ABERTO    = 2'd1,
        BLOQUEADO = 2'd2
    } estado_t;

    typedef enum logic [1:0] {
        V_CORRETO = 2'd0,
        V_PERTO   = 2'd1,
        V_LONGE   = 2'd2
    } veredito_t;

    estado_t    estado_r;
    logic [3:0] falhas_r;
    veredito_t  veredito_s;
    logic [3:0] falhas_inc_s;

    // Resolve the comparator verdict by priority. led0 beats led1, and
    // anything else (led2 or no LED at all) counts as a wrong attempt.
    always_comb begin
        veredito_s = V_LONGE;
        if (led0) begin
            veredito_s = V_CORRETO;
        end else if (led1) begin
            veredito_s = V_PERTO;
        end else if (led2) begin
            veredito_s = V_LONGE;
        end else begin
            veredito_s = V_LONGE;
        end
    end

    // Failure count after one more failed attempt, saturating at the limit.
    always_comb begin
        falhas_inc_s = falhas_r;
        if (falhas_r >= MAX_C) begin
            falhas_inc_s = MAX_C;
        end else begin
            falhas_inc_s = falhas_r + 4'd1;
        end
    end

    // Main FSM: state, failure counter and all registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            estado_r             <= FECHADO;
            falhas_r             <= 4'd0;
            aberto               <= 1'b0;
            bloqueado            <= 1'b0;
            dica_proxima         <= 1'b0;
            erro                 <= 1'b0;
            tentativas_restantes <= MAX_C;
            tempo_restante       <= 8'd0;
            ultima_diferenca     <= 4'd0;
        end else begin
            case (estado_r)
                FECHADO: begin
                    if (confirmar) begin
                        ultima_diferenca <= diferenca;
                        if (veredito_s == V_CORRETO) begin
                            estado_r             <= ABERTO;
                            aberto               <= 1'b1;
                            falhas_r             <= 4'd0;
                            tentativas_restantes <= MAX_C;
                            dica_proxima         <= 1'b0;
                            erro                 <= 1'b0;
                            tempo_restante       <= ABERTO_C;
                        end else begin
                            falhas_r     <= falhas_inc_s;
                            erro         <= 1'b1;
                            dica_proxima <= (veredito_s == V_PERTO);
                            if (falhas_inc_s == MAX_C) begin
                                estado_r             <= BLOQUEADO;
                                bloqueado            <= 1'b1;
                                tempo_restante       <= BLOQUEIO_C;
                                tentativas_restantes <= 4'd0;
                            end else begin
                                tentativas_restantes <= MAX_C - falhas_inc_s;
                            end
                        end
                    end
                end

                ABERTO: begin
                    // The <= 1 test also covers a zero count, so the
                    // timer never wraps.
                    if (fechar || (tempo_restante <= 8'd1)) begin
                        estado_r       <= FECHADO;
                        aberto         <= 1'b0;
                        tempo_restante <= 8'd0;
                    end else begin
                        tempo_restante <= tempo_restante - 8'd1;
                    end
                end

                BLOQUEADO: begin
                    // erro and dica_proxima keep the last attempt's values
                    // through the lockout.
                    if (tempo_restante <= 8'd1) begin
                        estado_r             <= FECHADO;
                        bloqueado            <= 1'b0;
                        falhas_r             <= 4'd0;
                        tentativas_restantes <= MAX_C;
                        tempo_restante       <= 8'd0;
                    end else begin
                        tempo_restante <= tempo_restante - 8'd1;
                    end
                end

                default: begin
                    estado_r             <= FECHADO;
                    falhas_r             <= 4'd0;
                    aberto               <= 1'b0;
                    bloqueado            <= 1'b0;
                    tentativas_restantes <= MAX_C;
                    tempo_restante       <= 8'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cofre_controle.sv
module tb_cofre_controle;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       confirmar = 1'b0;
    logic       fechar = 1'b0;
    logic       led0 = 1'b0;
    logic       led1 = 1'b0;
    logic       led2 = 1'b0;
    logic [3:0] diferenca = 4'd0;
    logic       aberto;
    logic       bloqueado;
    logic       dica_proxima;
    logic       erro;
    logic [3:0] tentativas_restantes;
    logic [7:0] tempo_restante;
    logic [3:0] ultima_diferenca;

    int applied = 0;
    int miscompares = 0;

    cofre_controle #(
        .MAX_TENTATIVAS(3),
        .TEMPO_BLOQUEIO(16),
        .TEMPO_ABERTO(32)
    ) dut (
        .clk(clk),
        .reset(reset),
        .confirmar(confirmar),
        .fechar(fechar),
        .led0(led0),
        .led1(led1),
        .led2(led2),
        .diferenca(diferenca),
        .aberto(aberto),
        .bloqueado(bloqueado),
        .dica_proxima(dica_proxima),
        .erro(erro),
        .tentativas_restantes(tentativas_restantes),
        .tempo_restante(tempo_restante),
        .ultima_diferenca(ultima_diferenca)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       conf;
        logic       fech;
        logic       l0;
        logic       l1;
        logic       l2;
        logic [3:0] dif;
        logic       e_ab;
        logic       e_bl;
        logic       e_dp;
        logic       e_er;
        logic [3:0] e_tr;
        logic [7:0] e_tm;
        logic [3:0] e_ud;
    } vec_t;

    vec_t vecs[13];

    // Drive the inputs, then advance one clock and sample 1 time unit later.
    task automatic drive_step(input logic r, input logic c, input logic f,
                              input logic a0, input logic a1, input logic a2,
                              input logic [3:0] d);
        reset = r; confirmar = c; fechar = f;
        led0 = a0; led1 = a1; led2 = a2; diferenca = d;
        @(posedge clk);
        #1;
        reset = 1'b0; confirmar = 1'b0; fechar = 1'b0;
        led0 = 1'b0; led1 = 1'b0; led2 = 1'b0; diferenca = 4'd0;
    endtask

    task automatic idle_step();
        drive_step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
    endtask

    task automatic check(input string nm, input logic ab, input logic bl,
                         input logic dp, input logic er, input logic [3:0] tr,
                         input logic [7:0] tm, input logic [3:0] ud);
        applied++;
        if ({aberto, bloqueado, dica_proxima, erro, tentativas_restantes,
             tempo_restante, ultima_diferenca} !==
            {ab, bl, dp, er, tr, tm, ud}) begin
            miscompares++;
            $display("FAIL %s: got ab=%0b bl=%0b dp=%0b er=%0b tr=%0d tm=%0d ud=%0d, expected ab=%0b bl=%0b dp=%0b er=%0b tr=%0d tm=%0d ud=%0d",
                     nm, aberto, bloqueado, dica_proxima, erro,
                     tentativas_restantes, tempo_restante, ultima_diferenca,
                     ab, bl, dp, er, tr, tm, ud);
        end
    endtask

    task automatic check_int(input string nm, input int got, input int exp_v);
        applied++;
        if (got != exp_v) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", nm, got, exp_v);
        end
    endtask

    initial begin
        int cnt;
        // rst conf fech l0 l1 l2 dif | ab bl dp er tr tm ud
        vecs[0]  = '{1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,4'd0, 1'b0,1'b0,1'b0,1'b0,4'd3,8'd0, 4'd0};
        vecs[1]  = '{1'b0,1'b1,1'b0,1'b0,1'b1,1'b0,4'd2, 1'b0,1'b0,1'b1,1'b1,4'd2,8'd0, 4'd2};
        vecs[2]  = '{1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,4'd7, 1'b0,1'b0,1'b1,1'b1,4'd2,8'd0, 4'd2};
        vecs[3]  = '{1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,4'd0, 1'b1,1'b0,1'b0,1'b0,4'd3,8'd32,4'd0};
        vecs[4]  = '{1'b0,1'b1,1'b0,1'b0,1'b0,1'b1,4'd9, 1'b1,1'b0,1'b0,1'b0,4'd3,8'd31,4'd0};
        vecs[5]  = '{1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,4'd0, 1'b0,1'b0,1'b0,1'b0,4'd3,8'd0, 4'd0};
        vecs[6]  = '{1'b0,1'b1,1'b0,1'b0,1'b0,1'b1,4'd9, 1'b0,1'b0,1'b0,1'b1,4'd2,8'd0, 4'd9};
        vecs[7]  = '{1'b0,1'b1,1'b0,1'b0,1'b1,1'b1,4'd3, 1'b0,1'b0,1'b1,1'b1,4'd1,8'd0, 4'd3};
        vecs[8]  = '{1'b0,1'b1,1'b0,1'b0,1'b0,1'b1,4'd9, 1'b0,1'b1,1'b0,1'b1,4'd0,8'd16,4'd9};
        vecs[9]  = '{1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,4'd0, 1'b0,1'b1,1'b0,1'b1,4'd0,8'd15,4'd9};
        vecs[10] = '{1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,4'd0, 1'b0,1'b1,1'b0,1'b1,4'd0,8'd14,4'd9};
        vecs[11] = '{1'b1,1'b1,1'b0,1'b1,1'b0,1'b0,4'd5, 1'b0,1'b0,1'b0,1'b0,4'd3,8'd0, 4'd0};
        vecs[12] = '{1'b0,1'b1,1'b0,1'b1,1'b0,1'b1,4'd1, 1'b1,1'b0,1'b0,1'b0,4'd3,8'd32,4'd1};

        for (int i = 0; i < 13; i++) begin
            drive_step(vecs[i].rst, vecs[i].conf, vecs[i].fech,
                       vecs[i].l0, vecs[i].l1, vecs[i].l2, vecs[i].dif);
            check($sformatf("vec%0d", i), vecs[i].e_ab, vecs[i].e_bl,
                  vecs[i].e_dp, vecs[i].e_er, vecs[i].e_tr,
                  vecs[i].e_tm, vecs[i].e_ud);
        end

        // Count down to tempo_restante==1, then fechar on that same cycle.
        for (int k = 1; k <= 31; k++) begin
            idle_step();
            check($sformatf("open_countdown_%0d", k), 1'b1, 1'b0, 1'b0, 1'b0,
                  4'd3, 8'(32 - k), 4'd1);
        end
        drive_step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
        check("fechar_at_tm1", 1'b0, 1'b0, 1'b0, 1'b0, 4'd3, 8'd0, 4'd1);
        idle_step();
        check("closed_after_tm1", 1'b0, 1'b0, 1'b0, 1'b0, 4'd3, 8'd0, 4'd1);

        // Natural auto-relock: the safe stays open for exactly 32 cycles.
        drive_step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
        cnt = 0;
        for (int k = 0; k < 100 && aberto === 1'b1; k++) begin
            cnt++;
            idle_step();
        end
        check_int("open_cycles", cnt, 32);
        check("auto_relock", 1'b0, 1'b0, 1'b0, 1'b0, 4'd3, 8'd0, 4'd0);

        // fechar on the fifth cycle of ABERTO.
        drive_step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
        idle_step(); idle_step(); idle_step();
        check("open_tm29", 1'b1, 1'b0, 1'b0, 1'b0, 4'd3, 8'd29, 4'd0);
        drive_step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
        check("fechar_cycle5", 1'b0, 1'b0, 1'b0, 1'b0, 4'd3, 8'd0, 4'd0);

        // Three wrong attempts lead to a 16-cycle lockout.
        drive_step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'd9);
        drive_step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'd9);
        check("second_fail", 1'b0, 1'b0, 1'b0, 1'b1, 4'd1, 8'd0, 4'd9);
        drive_step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'd9);
        check("lock_entry", 1'b0, 1'b1, 1'b0, 1'b1, 4'd0, 8'd16, 4'd9);
        cnt = 1;
        drive_step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
        check("lock_ignores_led0", 1'b0, 1'b1, 1'b0, 1'b1, 4'd0, 8'd15, 4'd9);
        for (int k = 0; k < 100 && bloqueado === 1'b1; k++) begin
            cnt++;
            idle_step();
        end
        check_int("lock_cycles", cnt, 16);
        check("lock_exit", 1'b0, 1'b0, 1'b0, 1'b1, 4'd3, 8'd0, 4'd9);

        // Reset together with confirmar while locked out at tempo_restante==7.
        drive_step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'd2);
        drive_step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'd2);
        drive_step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'd2);
        check("lock2_entry", 1'b0, 1'b1, 1'b1, 1'b1, 4'd0, 8'd16, 4'd2);
        for (int k = 0; k < 100 && tempo_restante !== 8'd7; k++) begin
            idle_step();
        end
        check("lock2_tm7", 1'b0, 1'b1, 1'b1, 1'b1, 4'd0, 8'd7, 4'd2);
        drive_step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'd4);
        check("reset_in_lock", 1'b0, 1'b0, 1'b0, 1'b0, 4'd3, 8'd0, 4'd0);
        idle_step();
        check("after_reset_idle", 1'b0, 1'b0, 1'b0, 1'b0, 4'd3, 8'd0, 4'd0);

        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
